// File: rtl/fft_stage_sequencer.sv
// Frame-level run controller for a radix-2 FFT: load N samples, step the stage
// controller through every stage with a per-stage watchdog, then unload the result.
module fft_stage_sequencer #(
  parameter int NUMSTAGES = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] ld_addr,
  output logic                 ld_we,
  output logic                 stage_en,
  output logic [2:0]           stage_num,
  input  logic                 stage_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMSTAGES-1:0] rd_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [NUMSTAGES-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]           LAST_STAGE = 3'(NUMSTAGES - 1);
  localparam logic [WDOG_W-1:0]    WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  if (NUMSTAGES < 1 || NUMSTAGES > 8) begin : g_bad_numstages
    $error("fft_stage_sequencer: NUMSTAGES must lie in 1..8 (stage_num is 3 bits)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fft_stage_sequencer: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_UNLOAD
  } state_e;

  state_e                 state_q, state_d;
  logic                   sd_q, sd_d;
  logic [NUMSTAGES-1:0]   ld_addr_q, ld_addr_d;
  logic [NUMSTAGES-1:0]   rd_addr_q, rd_addr_d;
  logic [2:0]             stage_num_q, stage_num_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   tog;

  // stage_done is a level that flips once per finished stage; an edge is a completion.
  assign sd_d = stage_done;
  assign tog  = stage_done ^ sd_q;

  assign in_ready  = (state_q == S_LOAD);
  assign ld_we     = in_valid & in_ready;
  assign stage_en  = (state_q == S_RUN);
  assign out_valid = (state_q == S_UNLOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign ld_addr   = ld_addr_q;
  assign rd_addr   = rd_addr_q;
  assign stage_num = stage_num_q;

  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    rd_addr_d   = rd_addr_q;
    stage_num_d = stage_num_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          err_d     = 1'b0;
          ld_addr_d = '0;
        end
      end

      S_LOAD: begin
        if (ld_we) begin
          ld_addr_d = ld_addr_q + 1'b1;
          if (ld_addr_q == LAST_ADDR) begin
            state_d     = S_RUN;
            stage_num_d = '0;
            wdog_d      = '0;
          end
        end
      end

      S_RUN: begin
        wdog_d = wdog_q + 1'b1;
        // A completion on the final watchdog cycle still counts as a completion.
        if (tog) begin
          wdog_d = '0;
          if (stage_num_q == LAST_STAGE) begin
            state_d   = S_UNLOAD;
            rd_addr_d = '0;
          end else begin
            state_d     = S_GAP;
            stage_num_d = stage_num_q + 1'b1;
          end
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wdog_d  = '0;
        end
      end

      S_GAP: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end

      S_UNLOAD: begin
        if (out_valid && out_ready) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sd_q <= sd_d;
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_addr_q   <= '0;
      rd_addr_q   <= '0;
      stage_num_q <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      rd_addr_q   <= rd_addr_d;
      stage_num_q <= stage_num_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

endmodule
